// File: rtl/wb_bus_watchdog_pkg.sv
// Shared types and constants for the Wishbone bus watchdog.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package wb_bus_watchdog_pkg;

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_ABORT = 1'b1
    } wd_state_e;

    localparam int FAULT_CNT_W = 8;
    localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = 8'hFF;

    function automatic logic [FAULT_CNT_W-1:0] fault_cnt_inc(input logic [FAULT_CNT_W-1:0] cnt);
        return (cnt == FAULT_CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/wb_bus_watchdog_cnt.sv
// Wait-cycle counter: counts consecutive waiting cycles, flags the TIMEOUT-th one.
// Latency: expire_o is combinational from inc_i and the registered count.
// Backpressure: none; clears whenever inc_i drops, on clr_i, or on expiry.
module wb_timeout_cnt
    import wb_bus_watchdog_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = inc_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Expiry restarts from zero, so the count can never wrap.
    always_comb begin
        cnt_d = '0;
        if (!clr_i && inc_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bus_watchdog.sv
// Wishbone pass-through that aborts a cycle with err after TIMEOUT unanswered cycles.
// Latency: zero-cycle combinational forwarding; the abort err is a single registered cycle.
// Backpressure: the master stalls on the slave as usual, but never longer than TIMEOUT cycles.
module wb_bus_watchdog
    import wb_bus_watchdog_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] wbm_adr_i,
    input  logic [31:0] wbm_dat_i,
    input  logic [3:0]  wbm_sel_i,
    input  logic        wbm_we_i,
    input  logic        wbm_cyc_i,
    input  logic        wbm_stb_i,
    input  logic [2:0]  wbm_cti_i,
    input  logic [1:0]  wbm_bte_i,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_ack_o,
    output logic        wbm_err_o,
    output logic        wbm_rty_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    output logic        wbs_we_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic [2:0]  wbs_cti_o,
    output logic [1:0]  wbs_bte_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,
    input  logic        wbs_rty_i,
    output logic        irq_o,
    output logic [31:0] fault_adr_o,
    output logic        fault_we_o,
    output logic [7:0]  fault_cnt_o
);

    wd_state_e               state_q, state_d;
    logic                    irq_q, irq_d;
    logic [31:0]             fault_adr_q, fault_adr_d;
    logic                    fault_we_q, fault_we_d;
    logic [FAULT_CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic wait_c;
    logic inc_c;
    logic trig_c;

    assign wait_c = en_i && wbm_cyc_i && wbm_stb_i && !(wbs_ack_i || wbs_err_i || wbs_rty_i);
    assign inc_c  = (state_q == ST_PASS) && wait_c;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .inc_i    (inc_c),
        .clr_i    (state_q == ST_ABORT),
        .expire_o (trig_c)
    );

    always_comb begin
        state_d = ST_PASS;
        if (state_q == ST_PASS && trig_c) begin
            state_d = ST_ABORT;
        end
    end

    // The abort cycle hides cyc/stb from the slave and swallows any late response.
    always_comb begin
        wbs_adr_o = wbm_adr_i;
        wbs_dat_o = wbm_dat_i;
        wbs_sel_o = wbm_sel_i;
        wbs_we_o  = wbm_we_i;
        wbs_cyc_o = wbm_cyc_i;
        wbs_stb_o = wbm_stb_i;
        wbs_cti_o = wbm_cti_i;
        wbs_bte_o = wbm_bte_i;
        wbm_dat_o = wbs_dat_i;
        wbm_ack_o = wbs_ack_i;
        wbm_err_o = wbs_err_i;
        wbm_rty_o = wbs_rty_i;
        if (state_q == ST_ABORT) begin
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_dat_o = '0;
            wbm_ack_o = 1'b0;
            wbm_err_o = 1'b1;
            wbm_rty_o = 1'b0;
        end
    end

    always_comb begin
        irq_d       = irq_q;
        fault_adr_d = fault_adr_q;
        fault_we_d  = fault_we_q;
        fault_cnt_d = fault_cnt_q;
        if (trig_c) begin
            irq_d       = 1'b1;
            fault_adr_d = wbm_adr_i;
            fault_we_d  = wbm_we_i;
            fault_cnt_d = fault_cnt_inc(fault_cnt_q);
        end else if (clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_PASS;
            irq_q       <= 1'b0;
            fault_adr_q <= '0;
            fault_we_q  <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            fault_adr_q <= fault_adr_d;
            fault_we_q  <= fault_we_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign irq_o       = irq_q;
    assign fault_adr_o = fault_adr_q;
    assign fault_we_o  = fault_we_q;
    assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Bench for wb_bus_watchdog with TIMEOUT=16: directed scenarios plus random traffic.
// Latency: every cycle is compared against a run-length reference model.
// Backpressure: the bench master drops its request once it sees ack/err/rty.
module tb_wb_bus_watchdog;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [31:0] s_dat_in;
    logic        s_ack_in, s_err_in, s_rty_in;

    logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, fault_adr_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic        irq_o, fault_we_o;
    logic [7:0]  fault_cnt_o;

    int total = 0;
    int bad   = 0;

    // Reference model: "in abort cycle" flag plus length of the current unanswered wait run.
    bit          m_abort;
    int          m_run;
    bit          m_irq;
    logic [31:0] m_fadr;
    bit          m_fwe;
    int          m_fcnt;

    logic        s_err, s_ack, s_stb, s_rsp;
    logic [31:0] s_dat;

    initial forever #5 clk = ~clk;

    wb_bus_watchdog #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .en_i        (en),
        .clr_i       (clr),
        .wbm_adr_i   (m_adr),
        .wbm_dat_i   (m_dat),
        .wbm_sel_i   (m_sel),
        .wbm_we_i    (m_we),
        .wbm_cyc_i   (m_cyc),
        .wbm_stb_i   (m_stb),
        .wbm_cti_i   (m_cti),
        .wbm_bte_i   (m_bte),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_o   (wbm_ack_o),
        .wbm_err_o   (wbm_err_o),
        .wbm_rty_o   (wbm_rty_o),
        .wbs_adr_o   (wbs_adr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_cti_o   (wbs_cti_o),
        .wbs_bte_o   (wbs_bte_o),
        .wbs_dat_i   (s_dat_in),
        .wbs_ack_i   (s_ack_in),
        .wbs_err_i   (s_err_in),
        .wbs_rty_i   (s_rty_in),
        .irq_o       (irq_o),
        .fault_adr_o (fault_adr_o),
        .fault_we_o  (fault_we_o),
        .fault_cnt_o (fault_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit w;
        bit trig;
        trig = 1'b0;
        if (rst) begin
            m_abort = 0; m_run = 0; m_irq = 0; m_fadr = '0; m_fwe = 0; m_fcnt = 0;
        end else begin
            if (m_abort) begin
                m_abort = 0;
                m_run   = 0;
            end else begin
                w = en && m_cyc && m_stb && !(s_ack_in || s_err_in || s_rty_in);
                if (!w) begin
                    m_run = 0;
                end else if (m_run == TO - 1) begin
                    trig    = 1'b1;
                    m_abort = 1;
                    m_run   = 0;
                    m_fadr  = m_adr;
                    m_fwe   = m_we;
                    m_fcnt  = (m_fcnt < 255) ? m_fcnt + 1 : 255;
                end else begin
                    m_run++;
                end
            end
            if (trig) m_irq = 1;
            else if (clr) m_irq = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("fwd_bus", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
                       {m_adr, m_dat, m_sel, m_we, m_cti, m_bte});
        chk("wbs_cyc", wbs_cyc_o, m_abort ? 1'b0 : m_cyc);
        chk("wbs_stb", wbs_stb_o, m_abort ? 1'b0 : m_stb);
        chk("wbm_dat", wbm_dat_o, m_abort ? 32'h0 : s_dat_in);
        chk("wbm_rsp", {wbm_ack_o, wbm_err_o, wbm_rty_o},
                       m_abort ? 3'b010 : {s_ack_in, s_err_in, s_rty_in});
        s_err = wbm_err_o;
        s_ack = wbm_ack_o;
        s_stb = wbs_stb_o;
        s_dat = wbm_dat_o;
        s_rsp = wbm_ack_o | wbm_err_o | wbm_rty_o;
        @(posedge clk);
        model_step();
        #1;
        chk("irq", irq_o, m_irq);
        chk("fault_adr", fault_adr_o, m_fadr);
        chk("fault_we", fault_we_o, m_fwe);
        chk("fault_cnt", fault_cnt_o, m_fcnt);
    endtask

    task automatic idle();
        m_cyc = 0; m_stb = 0; clr = 0;
        s_ack_in = 0; s_err_in = 0; s_rty_in = 0;
    endtask

    task automatic req(input logic [31:0] adr, input logic we);
        m_adr = adr; m_we = we; m_cyc = 1; m_stb = 1;
    endtask

    initial begin
        bit          in_txn;
        int          age, dly, kind;
        rst = 1; en = 1; clr = 0;
        m_adr = '0; m_dat = 32'h1234_5678; m_sel = 4'hF; m_we = 0;
        m_cyc = 0; m_stb = 0; m_cti = 3'b000; m_bte = 2'b00;
        s_dat_in = 32'hDEAD_BEEF; s_ack_in = 0; s_err_in = 0; s_rty_in = 0;
        m_abort = 0; m_run = 0; m_irq = 0; m_fadr = '0; m_fwe = 0; m_fcnt = 0;

        tick(); tick();
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_fcnt", fault_cnt_o, 8'd0);
        rst = 0;

        // Read answered in cycle 3.
        req(32'h0000_1040, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            s_ack_in = (c == 3);
            s_dat_in = 32'hCAFE_0000 + c;
            tick();
            chk("t1_err", s_err, 1'b0);
            if (c == 3) begin
                chk("t1_ack", s_ack, 1'b1);
                chk("t1_dat", s_dat, 32'hCAFE_0003);
            end
        end
        idle(); tick();
        chk("t1_fcnt", fault_cnt_o, 8'd0);

        // Hung read: err exactly in cycle TO, slave side hidden.
        req(32'h0000_3000, 1'b0);
        for (int c = 0; c <= TO; c++) begin
            tick();
            chk("t2_err", s_err, c == TO);
            chk("t2_stb", s_stb, c != TO);
        end
        idle(); tick();
        chk("t2_fadr", fault_adr_o, 32'h0000_3000);
        chk("t2_fwe", fault_we_o, 1'b0);
        chk("t2_fcnt", fault_cnt_o, 8'd1);
        chk("t2_irq", irq_o, 1'b1);

        clr = 1; tick(); clr = 0;
        // Ack on the last allowed cycle wins.
        req(32'h0000_4000, 1'b0);
        for (int c = 0; c < TO; c++) begin
            s_ack_in = (c == TO - 1);
            tick();
            chk("t3_err", s_err, 1'b0);
        end
        idle(); tick();
        chk("t3_irq", irq_o, 1'b0);
        // Ack one cycle late is swallowed by the abort.
        req(32'h0000_4004, 1'b0);
        for (int c = 0; c <= TO; c++) begin
            s_ack_in = (c == TO);
            tick();
        end
        chk("t3_late_err", s_err, 1'b1);
        chk("t3_late_ack", s_ack, 1'b0);
        idle(); tick();

        // 256 timed-out writes saturate the fault counter; clr on final trigger loses.
        for (int n = 0; n < 256; n++) begin
            req(32'h0001_0000 + n, 1'b1);
            for (int c = 0; c <= TO; c++) begin
                clr = (n == 255) && (c == TO - 1);
                tick();
                if (n == 255 && c == TO - 1) chk("t4_irq_set_wins", irq_o, 1'b1);
            end
            idle(); tick();
        end
        chk("t4_fcnt_sat", fault_cnt_o, 8'd255);
        chk("t4_fwe", fault_we_o, 1'b1);
        clr = 1; tick(); clr = 0;
        chk("t4_irq_clr", irq_o, 1'b0);

        // Disabled watchdog never aborts; enabling starts a fresh count.
        en = 0;
        req(32'h0000_6000, 1'b0);
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("t5_err_off", s_err, 1'b0);
            chk("t5_stb_off", s_stb, 1'b1);
        end
        en = 1;
        for (int c = 0; c <= TO; c++) begin
            tick();
            chk("t5_err_on", s_err, c == TO);
        end
        idle(); tick();

        // Reset in the middle of a hung read.
        req(32'h0000_5000, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        rst = 1; tick(); rst = 0;
        chk("t6_status", {irq_o, fault_adr_o, fault_we_o, fault_cnt_o}, 42'h0);
        for (int c = 0; c <= TO; c++) begin
            tick();
            chk("t6_err", s_err, c == TO);
        end
        idle(); tick();

        // Random traffic, checked every cycle by the model.
        in_txn = 0; age = 0; dly = 0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            clr = ($urandom_range(0, 19) == 0);
            en  = en ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 9) == 0);
            if (in_txn && (s_rsp || $urandom_range(0, 59) == 0)) begin
                in_txn = 0;
            end else if (!in_txn && $urandom_range(0, 2) == 0) begin
                in_txn = 1; age = 0;
                dly   = $urandom_range(0, 24);
                m_adr = $urandom;
                m_we  = $urandom_range(0, 1);
            end
            m_cyc = in_txn;
            m_stb = in_txn && ($urandom_range(0, 49) != 0);
            kind  = $urandom_range(0, 2);
            s_ack_in = in_txn && (age == dly) && (kind == 0);
            s_err_in = in_txn && (age == dly) && (kind == 1);
            s_rty_in = in_txn && (age == dly) && (kind == 2);
            s_dat_in = $urandom;
            m_dat    = $urandom;
            m_sel    = 4'($urandom);
            m_cti    = 3'($urandom);
            m_bte    = 2'($urandom);
            tick();
            if (in_txn) age++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
